// File: rtl/mvb_encode_ctr.sv
// mvb_encode_ctr: MVB transmit frame encoder, Manchester half-bits held 2 clocks each on the line driver.
module mvb_encode_ctr (
  input  logic        clk_6M,
  input  logic        rst,
  input  logic        tx_start,
  input  logic        frame_type,
  input  logic [4:0]  word_count,
  input  logic        tx_abort,
  input  logic [15:0] tx_word,
  output logic        word_req,
  output logic        tx_out,
  output logic        tx_en,
  output logic        busy,
  output logic        frame_done,
  output logic        param_err
);
  localparam logic [17:0] MASTER_DELIM = 18'b10_11_00_01_11_00_01_01_01;
  localparam logic [17:0] SLAVE_DELIM  = 18'b10_10_10_10_00_11_01_00_11;
  localparam logic [6:0]  CRC_POLY     = 7'h65;
  typedef enum logic [2:0] {IDLE, START_DELIM, DATA, CHECK, END_DELIM, DONE} state_t;
  state_t state, state_n;
  logic ph, ph_n, req_d, req_d_n, par, par_n, ld, legal;
  logic [4:0] hb, hb_n, ws, ws_n, cnt, cnt_n;
  logic [1:0] gc, gc_n;
  logic [31:0] sr, sr_n;
  logic [15:0] hold, hold_n;
  logic [6:0] crc, crc_n;
  logic word_req_n, tx_en_n, busy_n, frame_done_n, param_err_n;
  function automatic logic [31:0] manch(input logic [15:0] w);
    logic [31:0] r;
    for (int i = 0; i < 16; i++) r[2*i +: 2] = {w[i], ~w[i]};
    return r;
  endfunction
  function automatic logic [6:0] crc_word(input logic [6:0] c, input logic [15:0] w);
    logic [6:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) r = {r[5:0], 1'b0} ^ ((w[i] ^ r[6]) ? CRC_POLY : 7'h0);
    return r;
  endfunction
  assign tx_out = sr[31];
  assign legal = !frame_type || (word_count != 5'd0 && (word_count & (word_count - 5'd1)) == 5'd0);
  always_comb begin
    state_n = state;
    ph_n = (state != IDLE) && !ph;
    sr_n = ph ? {sr[30:0], 1'b0} : sr;
    hb_n = ph ? hb + 5'd1 : hb;
    ws_n = ws;
    gc_n = gc;
    cnt_n = cnt;
    crc_n = crc;
    par_n = par;
    req_d_n = word_req;
    hold_n = req_d ? tx_word : hold;
    word_req_n = 1'b0;
    tx_en_n = tx_en;
    busy_n = busy;
    frame_done_n = 1'b0;
    param_err_n = 1'b0;
    ld = 1'b0;
    case (state)
      IDLE: if (tx_start) begin
        if (legal) begin
          state_n = START_DELIM;
          sr_n = {frame_type ? SLAVE_DELIM : MASTER_DELIM, 14'b0};
          hb_n = 5'd0;
          ph_n = 1'b0;
          cnt_n = frame_type ? word_count : 5'd1;
          ws_n = 5'd0;
          gc_n = 2'd0;
          tx_en_n = 1'b1;
          busy_n = 1'b1;
          word_req_n = 1'b1;
        end else param_err_n = 1'b1;
      end
      START_DELIM: ld = hb == 5'd17 && ph;
      DATA: if (hb == 5'd31 && ph) begin
        ws_n = ws + 5'd1;
        gc_n = gc + 2'd1;
        hb_n = 5'd0;
        if (gc == 2'd3 || ws + 5'd1 == cnt) begin
          state_n = CHECK;
          sr_n = manch({~{crc, par ^ (^crc)}, 8'h00});
        end else ld = 1'b1;
      end
      CHECK: if (hb == 5'd15 && ph) begin
        hb_n = 5'd0;
        if (ws < cnt) ld = 1'b1;
        else begin
          state_n = END_DELIM;
          sr_n = 32'd0;
        end
      end
      END_DELIM: if (hb == 5'd1 && ph) begin
        state_n = DONE;
        sr_n = 32'd0;
        tx_en_n = 1'b0;
        frame_done_n = 1'b1;
      end
      default: begin
        state_n = IDLE;
        sr_n = 32'd0;
        busy_n = 1'b0;
      end
    endcase
    // a word continuing a group keeps the running CRC; any other load opens a new group
    if (ld) begin
      state_n = DATA;
      sr_n = manch(hold);
      hb_n = 5'd0;
      crc_n = crc_word(state == DATA ? crc : 7'd0, hold);
      par_n = (state == DATA ? par : 1'b0) ^ (^hold);
      word_req_n = {1'b0, ws_n} + 6'd1 < {1'b0, cnt};
    end
    if (tx_abort) begin
      state_n = IDLE;
      sr_n = 32'd0;
      ph_n = 1'b0;
      req_d_n = 1'b0;
      word_req_n = 1'b0;
      tx_en_n = 1'b0;
      busy_n = 1'b0;
      frame_done_n = 1'b0;
      param_err_n = 1'b0;
    end
  end
  always_ff @(posedge clk_6M) begin
    if (!rst) begin
      state <= IDLE;
      ph <= 1'b0;
      sr <= 32'd0;
      hb <= 5'd0;
      ws <= 5'd0;
      gc <= 2'd0;
      cnt <= 5'd0;
      crc <= 7'd0;
      par <= 1'b0;
      req_d <= 1'b0;
      hold <= 16'd0;
      word_req <= 1'b0;
      tx_en <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      param_err <= 1'b0;
    end else begin
      state <= state_n;
      ph <= ph_n;
      sr <= sr_n;
      hb <= hb_n;
      ws <= ws_n;
      gc <= gc_n;
      cnt <= cnt_n;
      crc <= crc_n;
      par <= par_n;
      req_d <= req_d_n;
      hold <= hold_n;
      word_req <= word_req_n;
      tx_en <= tx_en_n;
      busy <= busy_n;
      frame_done <= frame_done_n;
      param_err <= param_err_n;
    end
  end
endmodule

// File: tb/tb_mvb_encode_ctr.sv
// tb_mvb_encode_ctr: directed frames checked half-bit by half-bit against a long-division CRC model.
module tb_mvb_encode_ctr;
  logic clk_6M = 1'b0, rst = 1'b0, tx_start = 1'b0, frame_type = 1'b0, tx_abort = 1'b0;
  logic [4:0] word_count = 5'd0;
  logic [15:0] tx_word = 16'd0;
  logic word_req, tx_out, tx_en, busy, frame_done, param_err;
  int checks = 0, errors = 0;
  logic [15:0] words [16];
  bit exp_q [$];
  always #5 clk_6M = ~clk_6M;
  mvb_encode_ctr dut (
    .clk_6M(clk_6M), .rst(rst), .tx_start(tx_start), .frame_type(frame_type),
    .word_count(word_count), .tx_abort(tx_abort), .tx_word(tx_word), .word_req(word_req),
    .tx_out(tx_out), .tx_en(tx_en), .busy(busy), .frame_done(frame_done), .param_err(param_err)
  );
  // remainder of (group bits * x^7) divided by x^7+x^6+x^5+x^2+1, plus even parity, inverted
  function automatic logic [7:0] check_byte(input bit d [$]);
    logic [7:0] r;
    logic [6:0] c;
    bit p;
    r = 8'd0;
    p = 1'b0;
    for (int i = 0; i < d.size() + 7; i++) begin
      r = {r[6:0], (i < d.size()) ? d[i] : 1'b0};
      if (r[7]) r = r ^ 8'hE5;
      if (i < d.size()) p = p ^ d[i];
    end
    c = r[6:0];
    return ~{c, p ^ (^c)};
  endfunction
  task automatic build(input bit ft, input int n);
    logic [17:0] delim;
    logic [7:0] cb;
    bit grp [$];
    bit v;
    delim = ft ? 18'b10_10_10_10_00_11_01_00_11 : 18'b10_11_00_01_11_00_01_01_01;
    exp_q.delete();
    for (int i = 17; i >= 0; i--) exp_q.push_back(delim[i]);
    for (int w = 0; w < n; w++) begin
      for (int b = 15; b >= 0; b--) begin
        v = words[w][b];
        exp_q.push_back(v);
        exp_q.push_back(!v);
        grp.push_back(v);
      end
      if (w % 4 == 3 || w == n - 1) begin
        cb = check_byte(grp);
        for (int i = 7; i >= 0; i--) begin
          exp_q.push_back(cb[i]);
          exp_q.push_back(!cb[i]);
        end
        grp.delete();
      end
    end
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
  endtask
  // starts at a negedge with the DUT idle; returns at the negedge one cycle after DONE
  task automatic run_frame(input bit ft, input int n, input string name);
    int len, bad, first_bad, en_cnt, fd_cnt, fd_k, rq_cnt, rq_bad, e;
    logic busy_l, busy_l1;
    len = 36 + 64 * n + 32 * ((n + 3) / 4) + 4;
    bad = 0; first_bad = -1; en_cnt = 0; fd_cnt = 0; fd_k = -1; rq_cnt = 0; rq_bad = 0;
    busy_l = 1'b0; busy_l1 = 1'b1;
    build(ft, n);
    frame_type = ft;
    word_count = n[4:0];
    tx_start = 1'b1;
    for (int k = 0; k <= len + 1; k++) begin
      @(negedge clk_6M);
      tx_start = 1'b0;
      if (word_req) begin
        e = (rq_cnt == 0) ? 0 : 36 + 64 * (rq_cnt - 1) + 32 * ((rq_cnt - 1) / 4);
        if (k != e) rq_bad++;
        if (rq_cnt < 16) tx_word = words[rq_cnt];
        rq_cnt++;
      end
      if (tx_out !== ((k < exp_q.size() * 2) ? exp_q[k / 2] : 1'b0)) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
      if (tx_en) en_cnt++;
      if (frame_done) begin
        fd_cnt++;
        fd_k = k;
      end
      if (k == len) busy_l = busy;
      if (k == len + 1) busy_l1 = busy;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL %s stream: %0d bad clocks, first at %0d, want 0", name, bad, first_bad); end
    checks++;
    if (en_cnt !== len) begin errors++; $display("FAIL %s tx_en length: got %0d want %0d", name, en_cnt, len); end
    checks++;
    if (fd_cnt !== 1 || fd_k !== len) begin errors++; $display("FAIL %s frame_done: %0d pulses last at %0d, want 1 at %0d", name, fd_cnt, fd_k, len); end
    checks++;
    if (rq_cnt !== n || rq_bad !== 0) begin errors++; $display("FAIL %s word_req: %0d pulses %0d misplaced, want %0d and 0", name, rq_cnt, rq_bad, n); end
    checks++;
    if (busy_l !== 1'b1 || busy_l1 !== 1'b0) begin errors++; $display("FAIL %s busy around DONE: got %b%b want 10", name, busy_l, busy_l1); end
  endtask
  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk_6M);
    rst = 1'b1;
    @(negedge clk_6M);
    checks++;
    if ({word_req, tx_out, tx_en, busy, frame_done, param_err} !== 6'b0) begin
      errors++; $display("FAIL reset outputs: got %b want 000000", {word_req, tx_out, tx_en, busy, frame_done, param_err});
    end
  endtask
  task automatic test_master;
    words[0] = 16'h1234;
    run_frame(1'b0, 1, "master_1234");
  endtask
  task automatic test_slave8;
    for (int i = 0; i < 8; i++) words[i] = 16'(i + 1);
    run_frame(1'b1, 8, "slave8");
    words[0] = 16'hBEEF; words[1] = 16'h0000;
    run_frame(1'b1, 2, "slave2");
  endtask
  task automatic test_param_err;
    logic [4:0] bad_wc [2];
    bad_wc[0] = 5'd3; bad_wc[1] = 5'd0;
    for (int i = 0; i < 2; i++) begin
      frame_type = 1'b1; word_count = bad_wc[i]; tx_start = 1'b1;
      @(negedge clk_6M);
      tx_start = 1'b0;
      checks++;
      if ({param_err, tx_en, busy} !== 3'b100) begin errors++; $display("FAIL param_err wc=%0d: got %b want 100", bad_wc[i], {param_err, tx_en, busy}); end
      @(negedge clk_6M);
      checks++;
      if ({param_err, tx_en, busy} !== 3'b000) begin errors++; $display("FAIL param_err clear wc=%0d: got %b want 000", bad_wc[i], {param_err, tx_en, busy}); end
    end
    frame_type = 1'b1; word_count = 5'd3; tx_start = 1'b1; tx_abort = 1'b1;
    @(negedge clk_6M);
    frame_type = 1'b0; word_count = 5'd1;
    @(negedge clk_6M);
    tx_start = 1'b0; tx_abort = 1'b0;
    checks++;
    if ({param_err, tx_en, busy, word_req} !== 4'b0000) begin errors++; $display("FAIL start with abort: got %b want 0000", {param_err, tx_en, busy, word_req}); end
  endtask
  task automatic test_abort;
    int seen;
    for (int i = 0; i < 4; i++) words[i] = 16'hC000 + 16'(i);
    frame_type = 1'b1; word_count = 5'd4; tx_start = 1'b1;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_6M);
      tx_start = 1'b0;
      if (word_req) tx_word = words[0];
      if (tx_en) seen++;
    end
    tx_abort = 1'b1;
    @(negedge clk_6M);
    tx_abort = 1'b0;
    checks++;
    if (seen !== 100) begin errors++; $display("FAIL abort prelude tx_en: got %0d want 100", seen); end
    checks++;
    if ({tx_en, busy, tx_out, word_req} !== 4'b0000) begin errors++; $display("FAIL abort outputs: got %b want 0000", {tx_en, busy, tx_out, word_req}); end
    seen = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk_6M);
      if (frame_done || tx_en || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort aftermath: %0d active clocks want 0", seen); end
    words[0] = 16'h8001;
    run_frame(1'b0, 1, "master_after_abort");
  endtask
  task automatic test_rst_mid;
    int bad, perr;
    words[0] = 16'h5A5A;
    build(1'b0, 1);
    frame_type = 1'b0; word_count = 5'd1; tx_start = 1'b1;
    bad = 0; perr = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_6M);
      tx_start = (k >= 4 && k < 40);
      frame_type = (k >= 4 && k < 40);
      word_count = (k >= 4 && k < 40) ? 5'd3 : 5'd1;
      if (word_req) tx_word = words[0];
      if (tx_out !== exp_q[k / 2] || !tx_en) bad++;
      if (param_err) perr++;
    end
    rst = 1'b0;
    @(negedge clk_6M);
    checks++;
    if (bad !== 0 || perr !== 0) begin errors++; $display("FAIL start during busy: %0d bad clocks %0d param_err, want 0 0", bad, perr); end
    checks++;
    if ({word_req, tx_out, tx_en, busy, frame_done, param_err} !== 6'b0) begin
      errors++; $display("FAIL mid-frame rst: got %b want 000000", {word_req, tx_out, tx_en, busy, frame_done, param_err});
    end
    rst = 1'b1;
    repeat (2) @(negedge clk_6M);
    checks++;
    if ({tx_en, busy} !== 2'b00) begin errors++; $display("FAIL after rst idle: got %b want 00", {tx_en, busy}); end
  endtask
  task automatic test_back_to_back;
    words[0] = 16'hA5C3;
    run_frame(1'b0, 1, "b2b_first");
    words[0] = 16'h0F0F;
    run_frame(1'b0, 1, "b2b_second");
  endtask
  initial begin
    test_reset();
    test_master();
    test_slave8();
    test_param_err();
    test_abort();
    test_rst_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mvb_encode_ctr.md
# mvb_encode_ctr

Transmit-side MVB frame encoder and controller. It accepts a master or slave frame request from the link layer and fetches 16-bit data words through a request handshake. It serialises the frame as Manchester half-bits on the line driver: start delimiter, data, an 8-bit check sequence after every 64 data bits and after the last word, then the end delimiter. It is the transmit counterpart of the frame decode path and runs on the 6 MHz bus clock, with one half-bit lasting 2 clocks, for 1.5 Mbit/s.

## Interface
- MASTER_DELIM, 18'b10_11_00_01_11_00_01_01_01: master start delimiter half-bits, MSB first. Symbols are start bit, NH, NL, 0, NH, NL, 0, 0, 0.
- SLAVE_DELIM, 18'b10_10_10_10_00_11_01_00_11: slave start delimiter half-bits, MSB first. Symbols are 1, 1, 1, 1, NL, NH, 0, NL, NH.
- CRC_POLY, 7'h65: CRC generator x^7+x^6+x^5+x^2+1, with the x^7 term implicit.

Ports. Reset is rst, synchronous, active-low. The clock is clk_6M.
- clk_6M  in  1  bus clock, 6 MHz.
- rst  in  1  synchronous active-low reset.
- tx_start  in  1  one-cycle frame request.
- frame_type  in  1  0 = master, 1 = slave. Sampled with tx_start.
- word_count  in  5  slave data words; legal values are 1, 2, 4, 8, 16. Sampled with tx_start and ignored for master frames, which always carry 1 word.
- tx_abort  in  1  stop transmission immediately.
- tx_word  in  16  data word, MSB transmitted first.
- word_req  out  1  one-cycle request for the next data word.
- tx_out  out  1  Manchester line level; idle 0.
- tx_en  out  1  line driver enable.
- busy  out  1  high from frame acceptance until DONE.
- frame_done  out  1  one-cycle pulse when the frame completes normally.
- param_err  out  1  one-cycle pulse when a request is rejected.

## Operation
- Symbol encoding, two half-bits each: 1 = 10, 0 = 01, NH = 11, NL = 00. Each half-bit is held for 2 clocks.
- States:
  - IDLE
  - START_DELIM: 18 half-bits, 36 clocks.
  - DATA: 32 half-bits per word, 64 clocks.
  - CHECK: 16 half-bits, 32 clocks.
  - END_DELIM: one NL symbol, 4 clocks.
  - DONE: 1 clock.
- IDLE -> START_DELIM when tx_start=1 and the request is legal. At this point frame_type and word_count are latched, and the latched word count is forced to 1 for a master frame.
- Illegal request: a slave request with word_count not in {1, 2, 4, 8, 16}. The block pulses param_err and stays in IDLE.
- tx_start is ignored when busy=1.
- Word fetch:
  - word_req pulses in the first cycle of START_DELIM, for word 0.
  - It also pulses in the first cycle of each DATA word except the last, to fetch the next word.
  - tx_word is sampled into a hold register at the edge 2 cycles after word_req. The shifter loads from the hold register at the start of each word.
- Transitions out of DATA and CHECK:
  - DATA -> CHECK after the 4th word of a group, or after the last word.
  - CHECK -> DATA if words remain, otherwise CHECK -> END_DELIM.
  - END_DELIM -> DONE -> IDLE.
- Check sequence:
  - The 7-bit CRC register is cleared at the start of each group and shifts over the group's data bits, MSB first.
  - The 8th bit is even parity over the group's data bits plus the 7 CRC bits.
  - All 8 bits are inverted, then sent MSB first.
- Word count bookkeeping uses a 5-bit counter of words sent. A group counter wraps every 4 words.
- tx_abort has priority over everything except rst. At the next edge: tx_out=0, tx_en=0, state=IDLE, busy=0. No frame_done is produced.
- rst asserted at any time, including mid-frame, forces IDLE at the next edge, with all outputs 0.

## Timing
- Reset and IDLE values: tx_out=0, tx_en=0, busy=0, word_req=0, frame_done=0, param_err=0.
- All outputs are registered.
- tx_start sampled at edge E0:
  - The first half-bit of the delimiter, tx_en=1 and busy=1 are visible from E0.
  - word_req=1 at E0, and tx_word is sampled at E0+2.
- Frame length in clocks, counted from E0 until tx_en falls, is 36 + 64·N + 32·ceil(N/4) + 4:
  - master: 136
  - slave N=1: 136
  - N=2: 200
  - N=4: 328
  - N=16: 1192
- tx_en stays high through END_DELIM and is 0 in DONE.
- frame_done=1 and busy=1 for the DONE cycle. busy=0 the cycle after.
- A new tx_start is accepted in the cycle after DONE.
- Simultaneous tx_abort and tx_start in IDLE: the request is rejected and no param_err is raised.

## Test plan
- Master frame, tx_word=16'h1234: tx_out shows MASTER_DELIM, then the Manchester of 0x1234, then the check byte matching the software model, then 4 clocks low. tx_en is high for exactly 136 clocks. frame_done pulses once. word_req pulses exactly once.
- Slave frame, N=8, words 0x0001 through 0x0008: two check bytes, at clocks 36+256 and 36+512+32. word_req pulses 8 times, each one 64 clocks apart within a group. Total length 616 clocks.
- Slave request with word_count=3: param_err pulses for 1 cycle; tx_en and busy stay 0.
- tx_abort at clock 100 of an N=4 frame: tx_en=0 and busy=0 at the next edge. No frame_done. A following master frame transmits normally.
- rst low at clock 50 of a master frame: all outputs 0 at the next edge. tx_start held during busy is ignored.
- Back-to-back master frames, with tx_start in the cycle after frame_done: the second frame starts with no gap and both check bytes are correct.
